// File: rtl/vram_scan_arbiter_pkg.sv
// Shared VGA / frame-buffer constants and types for the scan-out arbiter slice.
// Values match the 640x480 timing generator feeding this block.
package vram_scan_arbiter_pkg;

    localparam int HD         = 640;
    localparam int VD         = 480;
    localparam int FB_WIDTH   = 320;
    localparam int FB_HEIGHT  = 240;
    localparam int PIX_W      = 12;
    localparam int ADDR_W     = 17;
    localparam int WQ_ENTRIES = 4;

    typedef logic [PIX_W-1:0] pixel_t;

endpackage

// File: rtl/vram_scan_arbiter_if.sv
// Write-request and RAM port bundle of the frame-buffer arbiter.
// The slave modport is the arbiter side; master is the requester/RAM side.
interface vram_scan_arbiter_if #(
    parameter int AW = vram_scan_arbiter_pkg::ADDR_W,
    parameter int DW = vram_scan_arbiter_pkg::PIX_W
);
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        output wr_valid, wr_addr, wr_data, mem_rdata,
        input  wr_ready, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, mem_rdata,
        output wr_ready, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/vram_scan_arbiter_sync_fifo.sv
// Small synchronous FIFO used as the game-logic write queue.
// Push is ignored when full, pop is ignored when empty; head data is registered storage only.
module sync_fifo #(
    parameter int WIDTH = 29,
    parameter int DEPTH = 4
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = DEPTH + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/vram_scan_arbiter.sv
// Frame-buffer RAM owner: display reads take every even visible pixel slot, queued
// game writes drain in the remaining slots, and VGA outputs are re-aligned to the read pipe.
module vram_scan_arbiter
    import vram_scan_arbiter_pkg::*;
#(
    parameter int FB_W     = FB_WIDTH,
    parameter int FB_H     = FB_HEIGHT,
    parameter int AW       = ADDR_W,
    parameter int DW       = PIX_W,
    parameter int WQ_DEPTH = WQ_ENTRIES
) (
    input  logic          pclk,
    input  logic          reset,
    input  logic [9:0]    i_h_cnt,
    input  logic [9:0]    i_v_cnt,
    input  logic          i_valid,
    input  logic          i_hsync_in,
    input  logic          i_vsync_in,
    vram_scan_arbiter_if.slave bus,
    output logic [DW-1:0] o_pix_rgb,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_frame_tick,
    output logic          o_wq_empty,
    output logic          o_wr_oob
);
    localparam logic [AW-1:0] FB_SIZE = AW'(FB_W * FB_H);
    localparam logic [AW-1:0] FB_W_K  = AW'(FB_W);

    logic [AW-1:0]    w_row;
    logic [AW-1:0]    w_col;
    logic [AW-1:0]    w_row_base;
    logic [AW-1:0]    w_disp_addr;
    logic [AW+DW-1:0] w_head;
    logic [AW-1:0]    w_head_addr;
    logic [DW-1:0]    w_head_data;
    logic             w_full;
    logic             w_empty;
    logic             w_disp_slot;
    logic             w_wr_slot;
    logic             w_in_range;

    logic             r_valid_d1;
    logic             r_valid_d2;
    logic             r_hs_d1;
    logic             r_hs_d2;
    logic             r_vs_d1;
    logic             r_vs_d2;
    logic             r_rd_d1;
    logic [DW-1:0]    r_pix;
    logic             r_vs_prev;
    logic             r_frame_tick;
    logic             r_wr_oob;

    sync_fifo #(
        .WIDTH (AW + DW),
        .DEPTH (WQ_DEPTH)
    ) u_wq (
        .pclk    (pclk),
        .reset   (reset),
        .i_push  (bus.wr_valid),
        .i_pop   (w_wr_slot),
        .i_data  ({bus.wr_addr, bus.wr_data}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_addr = w_head[AW+DW-1:DW];
    assign w_head_data = w_head[DW-1:0];
    assign w_in_range  = (w_head_addr < FB_SIZE);
    assign w_disp_slot = i_valid && !i_h_cnt[0];
    assign w_wr_slot   = !w_disp_slot && !w_empty;
    assign bus.wr_ready = !w_full;

    // Each stored pixel covers a 2x2 block of screen pixels, hence the halved counts.
    assign w_row = AW'(i_v_cnt >> 1);
    assign w_col = AW'(i_h_cnt >> 1);

    always_comb begin
        w_row_base = '0;
        for (int i = 0; i < AW; i++) begin
            if (FB_W_K[i]) w_row_base = w_row_base + (w_row << i);
        end
    end

    assign w_disp_addr = w_row_base + w_col;

    // RAM port mux; out-of-range queue entries are popped without touching the RAM.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (!reset) begin
            if (w_disp_slot) begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = w_disp_addr;
            end else if (w_wr_slot && w_in_range) begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = w_head_addr;
                bus.mem_wdata = w_head_data;
            end
        end
    end

    // Two-stage alignment pipe: slot cycle, RAM latency cycle, then presentation.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_valid_d1   <= 1'b0;
            r_valid_d2   <= 1'b0;
            r_hs_d1      <= 1'b1;
            r_hs_d2      <= 1'b1;
            r_vs_d1      <= 1'b1;
            r_vs_d2      <= 1'b1;
            r_rd_d1      <= 1'b0;
            r_pix        <= '0;
            r_vs_prev    <= 1'b1;
            r_frame_tick <= 1'b0;
            r_wr_oob     <= 1'b0;
        end else begin
            r_valid_d1   <= i_valid;
            r_valid_d2   <= r_valid_d1;
            r_hs_d1      <= i_hsync_in;
            r_hs_d2      <= r_hs_d1;
            r_vs_d1      <= i_vsync_in;
            r_vs_d2      <= r_vs_d1;
            r_rd_d1      <= w_disp_slot;
            if (r_rd_d1) r_pix <= bus.mem_rdata;
            r_vs_prev    <= i_vsync_in;
            r_frame_tick <= r_vs_prev && !i_vsync_in;
            if (w_wr_slot && !w_in_range) r_wr_oob <= 1'b1;
        end
    end

    assign o_pix_rgb    = r_valid_d2 ? r_pix : '0;
    assign o_hsync      = r_hs_d2;
    assign o_vsync      = r_vs_d2;
    assign o_frame_tick = r_frame_tick;
    assign o_wq_empty   = w_empty;
    assign o_wr_oob     = r_wr_oob;

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Self-checking bench for vram_scan_arbiter: behavioural frame-buffer/queue model checked
// every cycle, plus directed scenarios with hand-computed pixel and status values.
module tb_vram_scan_arbiter;
    import vram_scan_arbiter_pkg::*;

    localparam int AWT   = 17;
    localparam int DWT   = 12;
    localparam int FBW   = 320;
    localparam int FBSZ  = 76800;
    localparam int DEPTH = 4;

    logic           pclk = 1'b0;
    logic           reset;
    logic [9:0]     hCnt;
    logic [9:0]     vCnt;
    logic           valid;
    logic           hsIn;
    logic           vsIn;
    logic [DWT-1:0] pixRgb;
    logic           hsync;
    logic           vsync;
    logic           frameTick;
    logic           wqEmpty;
    logic           wrOob;

    int nCompared   = 0;
    int nMismatched = 0;

    vram_scan_arbiter_if #(.AW(AWT), .DW(DWT)) bus ();

    vram_scan_arbiter #(
        .FB_W     (320),
        .FB_H     (240),
        .AW       (AWT),
        .DW       (DWT),
        .WQ_DEPTH (DEPTH)
    ) dut (
        .pclk         (pclk),
        .reset        (reset),
        .i_h_cnt      (hCnt),
        .i_v_cnt      (vCnt),
        .i_valid      (valid),
        .i_hsync_in   (hsIn),
        .i_vsync_in   (vsIn),
        .bus          (bus),
        .o_pix_rgb    (pixRgb),
        .o_hsync      (hsync),
        .o_vsync      (vsync),
        .o_frame_tick (frameTick),
        .o_wq_empty   (wqEmpty),
        .o_wr_oob     (wrOob)
    );

    always #5 pclk = ~pclk;

    // Single-port RAM with one-cycle read latency.
    pixel_t devRam [FBSZ];
    always @(posedge pclk) begin
        if (bus.mem_en && !bus.mem_we && int'(bus.mem_addr) < FBSZ)
            bus.mem_rdata <= devRam[bus.mem_addr];
        if (bus.mem_en && bus.mem_we && int'(bus.mem_addr) < FBSZ)
            devRam[bus.mem_addr] <= bus.mem_wdata;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Model: frame-buffer contents, pending write list and short input history.
    typedef struct { int addr; int data; } wrEntry_t;
    wrEntry_t modelQ[$];
    bit [11:0] modelRam [FBSZ];
    int vldD1, vldD2, hsD1, hsD2, vsD1, vsD2, pixD1, pixD2, lastRead, modelOob;
    int writeCount = 0;
    int wrOnDisplay = 0;
    int lastWrAddr = -1;

    always @(negedge pclk) begin
        int expEn, expWe, expAddr, expData, readVal, oobNext, occ;
        bit disp;
        wrEntry_t head;
        disp = valid && !hCnt[0];
        if (bus.mem_en && bus.mem_we) begin
            writeCount++;
            lastWrAddr = int'(bus.mem_addr);
            if (disp) wrOnDisplay++;
        end
        if (reset) begin
            modelQ.delete();
            modelOob = 0;
            vldD1 = 0; vldD2 = 0;
            hsD1 = 1; hsD2 = 1; vsD1 = 1; vsD2 = 1;
            pixD1 = 0; pixD2 = 0; lastRead = 0;
        end else begin
            occ = modelQ.size();
            checkOutput("wr_ready", int'(bus.wr_ready), int'(occ < DEPTH));
            checkOutput("wq_empty", int'(wqEmpty), int'(occ == 0));
            checkOutput("pix_rgb", int'(pixRgb), (vldD2 != 0) ? pixD2 : 0);
            checkOutput("hsync", int'(hsync), hsD2);
            checkOutput("vsync", int'(vsync), vsD2);
            checkOutput("frame_tick", int'(frameTick), int'(vsD2 == 1 && vsD1 == 0));
            checkOutput("wr_oob", int'(wrOob), modelOob);
            expEn = 0; expWe = 0; expAddr = 0; expData = 0; oobNext = 0;
            readVal = lastRead;
            if (disp) begin
                expEn   = 1;
                expAddr = (int'(vCnt) / 2) * FBW + int'(hCnt) / 2;
                readVal = (expAddr < FBSZ) ? int'(modelRam[expAddr]) : 0;
            end else if (occ > 0) begin
                head = modelQ.pop_front();
                if (head.addr < FBSZ) begin
                    expEn = 1; expWe = 1;
                    expAddr = head.addr; expData = head.data;
                    modelRam[head.addr] = 12'(head.data);
                end else begin
                    oobNext = 1;
                end
            end
            checkOutput("mem_en", int'(bus.mem_en), expEn);
            checkOutput("mem_we", int'(bus.mem_we), expWe);
            if (expEn != 0) checkOutput("mem_addr", int'(bus.mem_addr), expAddr);
            if (expWe != 0) checkOutput("mem_wdata", int'(bus.mem_wdata), expData);
            if (bus.wr_valid && occ < DEPTH)
                modelQ.push_back('{addr: int'(bus.wr_addr), data: int'(bus.wr_data)});
            lastRead = readVal;
            vldD2 = vldD1; vldD1 = int'(valid);
            hsD2 = hsD1;   hsD1 = int'(hsIn);
            vsD2 = vsD1;   vsD1 = int'(vsIn);
            pixD2 = pixD1; pixD1 = lastRead;
            modelOob = modelOob | oobNext;
        end
    end

    task automatic applyStimulus(input bit v, input int h, input int vc, input bit hs, input bit vs,
                                 input bit wv, input int wa, input int wd);
        valid        = v;
        hCnt         = 10'(h);
        vCnt         = 10'(vc);
        hsIn         = hs;
        vsIn         = vs;
        bus.wr_valid = wv;
        bus.wr_addr  = AWT'(wa);
        bus.wr_data  = DWT'(wd);
        @(posedge pclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
    endtask

    int obs [16];
    int expPix [3][4] = '{'{12'hF00, 12'hF00, 12'h0F0, 12'h0F0},
                          '{12'hF00, 12'hF00, 12'h0F0, 12'h0F0},
                          '{12'h00F, 12'h00F, 12'hABC, 12'hABC}};
    int preAddr [6] = '{0, 1, 2, 3, 320, 321};
    int preData [6] = '{12'hF00, 12'h0F0, 12'h123, 12'h456, 12'h00F, 12'hABC};
    int wc0;

    initial begin
        reset = 1'b1;
        valid = 1'b0; hCnt = '0; vCnt = '0; hsIn = 1'b1; vsIn = 1'b1;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        idle(3);
        checkOutput("rst_hsync", int'(hsync), 1);
        checkOutput("rst_vsync", int'(vsync), 1);
        checkOutput("rst_pix", int'(pixRgb), 0);
        checkOutput("rst_wr_ready", int'(bus.wr_ready), 1);
        checkOutput("rst_wq_empty", int'(wqEmpty), 1);
        checkOutput("rst_mem_en", int'(bus.mem_en), 0);
        checkOutput("rst_wr_oob", int'(wrOob), 0);
        checkOutput("rst_frame_tick", int'(frameTick), 0);
        reset = 1'b0;
        idle(2);

        $display("[TB] preloading frame buffer through the write queue");
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1, 1, 1, preAddr[i], preData[i]);
        idle(4);
        checkOutput("preload_empty", int'(wqEmpty), 1);
        checkOutput("preload_ram320", int'(devRam[320]), 12'h00F);

        $display("[TB] scanning lines 0..2");
        for (int vc = 0; vc < 3; vc++) begin
            for (int h = 0; h < 10; h++) begin
                applyStimulus(1, h, vc, 1, 1, 0, 0, 0);
                obs[h] = int'(pixRgb);
            end
            for (int p = 0; p < 4; p++)
                checkOutput($sformatf("line%0d_px%0d", vc, p), obs[p + 1], expPix[vc][p]);
            applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
            applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
            idle(2);
        end

        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("frame_tick_hi", int'(frameTick), 1);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("frame_tick_lo", int'(frameTick), 0);
        idle(3);

        $display("[TB] four writes during display slots");
        wc0 = writeCount;
        for (int i = 0; i < 4; i++) applyStimulus(1, 8 + 2 * i, 4, 1, 1, 1, 1000 + i, 12'h100 + i);
        checkOutput("aw_full_ready", int'(bus.wr_ready), 0);
        for (int h = 15; h < 23; h++) applyStimulus(1, h, 4, 1, 1, 0, 0, 0);
        checkOutput("aw_commit_count", writeCount - wc0, 4);
        checkOutput("aw_on_display", wrOnDisplay, 0);
        checkOutput("aw_last_addr", lastWrAddr, 1003);
        idle(3);

        $display("[TB] boundary addresses in blanking");
        checkOutput("oob_before", int'(wrOob), 0);
        wc0 = writeCount;
        applyStimulus(0, 0, 0, 1, 1, 1, 76799, 12'h5A5);
        applyStimulus(0, 0, 0, 1, 1, 1, 76800, 12'hFFF);
        idle(3);
        checkOutput("oob_ram_last", int'(devRam[76799]), 12'h5A5);
        checkOutput("oob_write_count", writeCount - wc0, 1);
        checkOutput("oob_sticky", int'(wrOob), 1);

        $display("[TB] push and pop in one cycle at two entries");
        wc0 = writeCount;
        applyStimulus(1, 0, 5, 1, 1, 1, 2000, 12'h201);
        applyStimulus(1, 2, 5, 1, 1, 1, 2001, 12'h202);
        applyStimulus(1, 3, 5, 1, 1, 1, 2002, 12'h203);
        applyStimulus(1, 4, 5, 1, 1, 1, 2003, 12'h204);
        applyStimulus(1, 6, 5, 1, 1, 1, 2004, 12'h205);
        checkOutput("pp_full_ready", int'(bus.wr_ready), 0);
        idle(6);
        checkOutput("pp_commit_count", writeCount - wc0, 5);
        checkOutput("pp_last_addr", lastWrAddr, 2004);

        $display("[TB] reset with three queued writes");
        applyStimulus(1, 0, 6, 0, 0, 1, 3000, 12'h301);
        applyStimulus(1, 2, 6, 0, 0, 1, 3001, 12'h302);
        applyStimulus(1, 4, 6, 0, 0, 1, 3002, 12'h303);
        checkOutput("mr_queued", int'(wqEmpty), 0);
        reset = 1'b1;
        applyStimulus(1, 6, 6, 0, 0, 0, 0, 0);
        checkOutput("mr_hsync", int'(hsync), 1);
        checkOutput("mr_vsync", int'(vsync), 1);
        reset = 1'b0;
        wc0 = writeCount;
        idle(5);
        checkOutput("mr_no_writes", writeCount - wc0, 0);
        checkOutput("mr_empty", int'(wqEmpty), 1);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
